// File: rtl/gate16_checker.sv
// gate16_checker: receiving end of the Not16/And16/Or16 stimulus path.
// Each accepted tuple (a, b, observed ~a, a&b, a|b) is compared against
// locally recomputed results. The block counts vectors and mismatches and
// captures the first failing vector. It reports pass/fail once NUM_VEC
// vectors have been checked.
module gate16_checker #(
    parameter int WIDTH   = 16,
    parameter int NUM_VEC = 16,
    parameter int CNT_W   = 16,
    parameter int ERR_W   = 8
) (
    input  logic             clock,
    input  logic             reset_n,
    input  logic             start,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic [WIDTH-1:0] nota,
    input  logic [WIDTH-1:0] andab,
    input  logic [WIDTH-1:0] orab,
    output logic             busy,
    output logic             done,
    output logic             pass,
    output logic [CNT_W-1:0] vec_count,
    output logic [ERR_W-1:0] err_count,
    output logic [CNT_W-1:0] fail_index,
    output logic [WIDTH-1:0] fail_a,
    output logic [WIDTH-1:0] fail_b,
    output logic [2:0]       fail_mask
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_RUN,
        S_DONE
    } state_t;

    state_t             r_state;
    state_t             w_nextState;

    logic [CNT_W-1:0]   r_vecCount;
    logic [ERR_W-1:0]   r_errCount;
    logic [CNT_W-1:0]   r_failIndex;
    logic [WIDTH-1:0]   r_failA;
    logic [WIDTH-1:0]   r_failB;
    logic [2:0]         r_failMask;

    logic               w_accept;
    logic               w_clear;
    logic               w_lastVec;
    logic [2:0]         w_mism;

    // The handshake is a pure decode of the registered state, so in_valid
    // never reaches in_ready combinationally.
    assign in_ready  = (r_state == S_RUN);
    assign w_accept  = in_valid & in_ready;
    assign w_clear   = start & ((r_state == S_IDLE) | (r_state == S_DONE));
    assign w_lastVec = (r_vecCount == CNT_W'(NUM_VEC - 1));

    // The bit order of w_mism matches fail_mask: bit0 not, bit1 and, bit2 or.
    assign w_mism = {(orab  != (a | b)),
                     (andab != (a & b)),
                     (nota  != ~a)};

    // State register. Reset is synchronous and returns the block to IDLE.
    always_ff @(posedge clock) begin
        if (!reset_n) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_nextState;
        end
    end

    // Next-state logic. start matters only in IDLE and DONE. The final
    // accept in RUN moves the block to DONE.
    always_comb begin
        w_nextState = r_state;
        case (r_state)
            S_IDLE:  if (start) w_nextState = S_RUN;
            S_RUN:   if (w_accept && w_lastVec) w_nextState = S_DONE;
            S_DONE:  if (start) w_nextState = S_RUN;
            default: w_nextState = S_IDLE;
        endcase
    end

    // Counters and first-failure capture. They clear on reset and on every
    // run start, and update on each accepted tuple. err_count saturates.
    // Only the first mismatch of a run is captured.
    always_ff @(posedge clock) begin
        if (!reset_n || w_clear) begin
            r_vecCount  <= '0;
            r_errCount  <= '0;
            r_failIndex <= '0;
            r_failA     <= '0;
            r_failB     <= '0;
            r_failMask  <= '0;
        end else if (w_accept) begin
            r_vecCount <= r_vecCount + 1'b1;
            if (w_mism != 3'b000) begin
                if (r_errCount != {ERR_W{1'b1}}) begin
                    r_errCount <= r_errCount + 1'b1;
                end
                if (r_errCount == '0) begin
                    r_failIndex <= r_vecCount;
                    r_failA     <= a;
                    r_failB     <= b;
                    r_failMask  <= w_mism;
                end
            end
        end
    end

    assign busy       = (r_state == S_RUN);
    assign done       = (r_state == S_DONE);
    assign pass       = done & (r_errCount == '0);
    assign vec_count  = r_vecCount;
    assign err_count  = r_errCount;
    assign fail_index = r_failIndex;
    assign fail_a     = r_failA;
    assign fail_b     = r_failB;
    assign fail_mask  = r_failMask;

endmodule

// File: tb/tb_gate16_checker.sv
// Directed testbench for gate16_checker. Two instances share the same
// stimulus: the main one has ERR_W=8, and a second one has ERR_W=2 so that
// err_count saturation can be observed.
module tb_gate16_checker;

    logic        clock;
    logic        reset_n;
    logic        start;
    logic        in_valid;
    logic [15:0] a, b, nota, andab, orab;

    logic        in_ready, busy, done, pass;
    logic [15:0] vec_count, fail_index, fail_a, fail_b;
    logic [7:0]  err_count;
    logic [2:0]  fail_mask;

    logic        smInReady, smBusy, smDone, smPass;
    logic [15:0] smVecCount, smFailIndex, smFailA, smFailB;
    logic [1:0]  smErrCount;
    logic [2:0]  smFailMask;

    int numCompared;
    int numMismatched;

    localparam logic [15:0] GA = 16'h0095;
    localparam logic [15:0] GB = 16'h00BA;
    localparam logic [15:0] GN = 16'hFF6A;
    localparam logic [15:0] GAND = 16'h0090;
    localparam logic [15:0] GOR = 16'h00BF;

    gate16_checker #(.WIDTH(16), .NUM_VEC(16), .CNT_W(16), .ERR_W(8)) dut (
        .clock(clock), .reset_n(reset_n), .start(start), .in_valid(in_valid),
        .in_ready(in_ready), .a(a), .b(b), .nota(nota), .andab(andab), .orab(orab),
        .busy(busy), .done(done), .pass(pass), .vec_count(vec_count),
        .err_count(err_count), .fail_index(fail_index), .fail_a(fail_a),
        .fail_b(fail_b), .fail_mask(fail_mask)
    );

    gate16_checker #(.WIDTH(16), .NUM_VEC(16), .CNT_W(16), .ERR_W(2)) dutSmall (
        .clock(clock), .reset_n(reset_n), .start(start), .in_valid(in_valid),
        .in_ready(smInReady), .a(a), .b(b), .nota(nota), .andab(andab), .orab(orab),
        .busy(smBusy), .done(smDone), .pass(smPass), .vec_count(smVecCount),
        .err_count(smErrCount), .fail_index(smFailIndex), .fail_a(smFailA),
        .fail_b(smFailB), .fail_mask(smFailMask)
    );

    // Free-running clock with a 10 ns period.
    initial begin
        clock = 1'b0;
        forever #5 clock = ~clock;
    end

    // Advance one clock edge, then wait until outputs are stable.
    task automatic tick;
        @(posedge clock);
        #1;
    endtask

    // Present one tuple for exactly one edge.
    task automatic feedVec(input logic [15:0] va, vb, vn, vand, vor);
        a = va; b = vb; nota = vn; andab = vand; orab = vor;
        in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
    endtask

    // Pulse start for one edge.
    task automatic startRun;
        start = 1'b1;
        tick();
        start = 1'b0;
    endtask

    task automatic test_reset;
        reset_n = 1'b0; start = 1'b1; in_valid = 1'b1;
        repeat (3) tick();
        numCompared++;
        if (in_ready !== 1'b0) begin numMismatched++; $display("[TB] FAIL reset_in_ready: got %0b expected 0", in_ready); end
        numCompared++;
        if (busy !== 1'b0 || done !== 1'b0 || pass !== 1'b0) begin numMismatched++; $display("[TB] FAIL reset_flags: got busy=%0b done=%0b pass=%0b expected 0/0/0", busy, done, pass); end
        numCompared++;
        if (vec_count !== 16'd0 || err_count !== 8'd0 || fail_index !== 16'd0 || fail_mask !== 3'd0) begin
            numMismatched++;
            $display("[TB] FAIL reset_counters: got vec=%0d err=%0d idx=%0d mask=%0b expected all 0", vec_count, err_count, fail_index, fail_mask);
        end
        reset_n = 1'b1; start = 1'b0; in_valid = 1'b0;
        repeat (2) tick();
        numCompared++;
        if (busy !== 1'b0 || done !== 1'b0) begin numMismatched++; $display("[TB] FAIL idle_hold: got busy=%0b done=%0b expected 0/0", busy, done); end
    endtask

    task automatic test_clean_run;
        int busyCycles;
        busyCycles = 0;
        startRun();
        for (int i = 0; i < 16; i++) begin
            if (busy === 1'b1) busyCycles++;
            feedVec(GA, GB, GN, GAND, GOR);
        end
        numCompared++;
        if (busyCycles !== 16) begin numMismatched++; $display("[TB] FAIL clean_busy_cycles: got %0d expected 16", busyCycles); end
        numCompared++;
        if (done !== 1'b1 || pass !== 1'b1 || busy !== 1'b0) begin numMismatched++; $display("[TB] FAIL clean_done: got done=%0b pass=%0b busy=%0b expected 1/1/0", done, pass, busy); end
        numCompared++;
        if (vec_count !== 16'd16 || err_count !== 8'd0) begin numMismatched++; $display("[TB] FAIL clean_counts: got vec=%0d err=%0d expected 16/0", vec_count, err_count); end
    endtask

    task automatic test_faults;
        startRun();
        for (int i = 0; i < 16; i++) begin
            if (i == 5)      feedVec(GA, GB, GN, GAND, 16'h00BE);
            else if (i == 9) feedVec(GA, GB, GN, 16'h0091, GOR);
            else             feedVec(GA, GB, GN, GAND, GOR);
        end
        numCompared++;
        if (err_count !== 8'd2 || smErrCount !== 2'd2) begin numMismatched++; $display("[TB] FAIL fault_err_count: got %0d/%0d expected 2/2", err_count, smErrCount); end
        numCompared++;
        if (fail_index !== 16'd5) begin numMismatched++; $display("[TB] FAIL fault_index: got %0d expected 5", fail_index); end
        numCompared++;
        if (fail_a !== 16'h0095 || fail_b !== 16'h00BA) begin numMismatched++; $display("[TB] FAIL fault_operands: got a=%h b=%h expected 0095/00ba", fail_a, fail_b); end
        numCompared++;
        if (fail_mask !== 3'b100) begin numMismatched++; $display("[TB] FAIL fault_mask: got %b expected 100", fail_mask); end
        numCompared++;
        if (done !== 1'b1 || pass !== 1'b0) begin numMismatched++; $display("[TB] FAIL fault_pass: got done=%0b pass=%0b expected 1/0", done, pass); end
    endtask

    task automatic test_gaps;
        logic [3:0] pat;
        int expCount;
        int cyc;
        pat = 4'b1001;
        expCount = 0;
        cyc = 0;
        startRun();
        a = GA; b = GB; nota = GN; andab = GAND; orab = GOR;
        while (expCount < 16 && cyc < 100) begin
            in_valid = pat[cyc % 4];
            start = (cyc == 6);
            tick();
            if (in_valid) expCount++;
            in_valid = 1'b0;
            start = 1'b0;
            numCompared++;
            if (vec_count !== 16'(expCount)) begin numMismatched++; $display("[TB] FAIL gap_count c%0d: got %0d expected %0d", cyc, vec_count, expCount); end
            numCompared++;
            if (done !== (expCount == 16)) begin numMismatched++; $display("[TB] FAIL gap_done c%0d: got %0b expected %0b", cyc, done, (expCount == 16)); end
            cyc++;
        end
        numCompared++;
        if (expCount != 16) begin numMismatched++; $display("[TB] FAIL gap_timeout: got %0d accepts expected 16", expCount); end
        for (int i = 0; i < 3; i++) feedVec(16'h1111, 16'h2222, 16'h0, 16'h0, 16'h0);
        numCompared++;
        if (vec_count !== 16'd16 || err_count !== 8'd0 || done !== 1'b1 || pass !== 1'b1) begin
            numMismatched++;
            $display("[TB] FAIL done_ignore: got vec=%0d err=%0d done=%0b pass=%0b expected 16/0/1/1", vec_count, err_count, done, pass);
        end
    endtask

    task automatic test_saturation_restart;
        startRun();
        for (int i = 0; i < 16; i++) feedVec(16'h1234, 16'h00FF, 16'h1234, 16'hFFCB, 16'hEC00);
        numCompared++;
        if (smErrCount !== 2'd3 || err_count !== 8'd16) begin numMismatched++; $display("[TB] FAIL sat_err_count: got %0d/%0d expected 3/16", smErrCount, err_count); end
        numCompared++;
        if (smFailIndex !== 16'd0 || smFailMask !== 3'b111 || smFailA !== 16'h1234) begin
            numMismatched++;
            $display("[TB] FAIL sat_capture: got idx=%0d mask=%b a=%h expected 0/111/1234", smFailIndex, smFailMask, smFailA);
        end
        numCompared++;
        if (smPass !== 1'b0 || smDone !== 1'b1) begin numMismatched++; $display("[TB] FAIL sat_pass: got done=%0b pass=%0b expected 1/0", smDone, smPass); end
        startRun();
        numCompared++;
        if (smVecCount !== 16'd0 || smErrCount !== 2'd0 || smFailMask !== 3'd0 || smFailA !== 16'd0 || smBusy !== 1'b1) begin
            numMismatched++;
            $display("[TB] FAIL restart_clear: got vec=%0d err=%0d mask=%b a=%h busy=%0b expected 0/0/0/0/1", smVecCount, smErrCount, smFailMask, smFailA, smBusy);
        end
        for (int i = 0; i < 16; i++) feedVec(GA, GB, GN, GAND, GOR);
        numCompared++;
        if (smPass !== 1'b1 || pass !== 1'b1) begin numMismatched++; $display("[TB] FAIL restart_pass: got %0b/%0b expected 1/1", smPass, pass); end
    endtask

    task automatic test_reset_mid_run;
        startRun();
        for (int i = 0; i < 7; i++) begin
            if (i == 2) feedVec(GA, GB, 16'h0000, GAND, GOR);
            else        feedVec(GA, GB, GN, GAND, GOR);
        end
        numCompared++;
        if (vec_count !== 16'd7 || err_count !== 8'd1) begin numMismatched++; $display("[TB] FAIL pre_reset: got vec=%0d err=%0d expected 7/1", vec_count, err_count); end
        reset_n = 1'b0;
        tick();
        reset_n = 1'b1;
        numCompared++;
        if (busy !== 1'b0 || in_ready !== 1'b0 || vec_count !== 16'd0 || err_count !== 8'd0 || fail_mask !== 3'd0) begin
            numMismatched++;
            $display("[TB] FAIL mid_reset: got busy=%0b rdy=%0b vec=%0d err=%0d mask=%b expected 0/0/0/0/0", busy, in_ready, vec_count, err_count, fail_mask);
        end
        startRun();
        for (int i = 0; i < 16; i++) feedVec(GA, GB, GN, GAND, GOR);
        numCompared++;
        if (done !== 1'b1 || pass !== 1'b1 || vec_count !== 16'd16) begin
            numMismatched++;
            $display("[TB] FAIL post_reset_run: got done=%0b pass=%0b vec=%0d expected 1/1/16", done, pass, vec_count);
        end
    endtask

    // Run every scenario in sequence, then print the summary.
    initial begin
        numCompared = 0;
        numMismatched = 0;
        reset_n = 1'b0; start = 1'b0; in_valid = 1'b0;
        a = '0; b = '0; nota = '0; andab = '0; orab = '0;
        test_reset();
        test_clean_run();
        test_faults();
        test_gaps();
        test_saturation_restart();
        test_reset_mid_run();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", numCompared, numMismatched);
        $finish;
    end

endmodule
